// File: rtl/kernel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kernel_ctrl_pkg
// Description : Register map offsets, CTRL bit positions and AXI4-Lite
//               FSM state types shared by the kernel control slave.
// Revision    : 1.0 - initial release
// ============================================================================
package kernel_ctrl_pkg;

    // Byte offsets of the register map (decode is word-aligned)
    localparam int ADDR_CTRL = 'h00;
    localparam int ADDR_GIE  = 'h04;
    localparam int ADDR_IER  = 'h08;
    localparam int ADDR_ISR  = 'h0C;
    localparam int ADDR_ARG0 = 'h10;

    // Bit positions inside the CTRL register
    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_IDLE  = 2;
    localparam int CTRL_READY = 3;
    localparam int CTRL_AUTO  = 7;

    typedef enum logic [1:0] {
        W_ADDR = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [0:0] {
        R_ADDR = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/kernel_ctrl_s_axi_if.sv
`default_nettype none
// ============================================================================
// Module      : kernel_ctrl_s_axi_if
// Description : AXI4-Lite bundle (32-bit data) between host and the kernel
//               control slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface kernel_ctrl_s_axi_if #(
    parameter int ADDR_W = 12
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface
`default_nettype wire

// File: rtl/kernel_ctrl_s_axi.sv
`default_nettype none
// ============================================================================
// Module      : kernel_ctrl_s_axi
// Description : AXI4-Lite slave with kernel CTRL/GIE/IER/ISR registers and
//               64-bit scalar arguments; drives ap_start and the interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_ctrl_s_axi
    import kernel_ctrl_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_NUM_ARGS         = 4
) (
    input  wire logic                      ap_clk,
    input  wire logic                      ap_srst,
    kernel_ctrl_s_axi_if.slave             s_axi,
    output logic                           ap_start,
    input  wire logic                      ap_done,
    input  wire logic                      ap_idle,
    input  wire logic                      ap_ready,
    output logic                           interrupt,
    output logic [64*C_NUM_ARGS-1:0]       args
);

    localparam int c_aw     = C_S_AXI_ADDR_WIDTH;
    localparam int c_strb_w = C_S_AXI_DATA_WIDTH / 8;

    // Byte-lane merge of a write into an existing 32-bit word
    function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < c_strb_w; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    wr_state_e         r_wstate;
    rd_state_e         r_rstate;
    logic              r_awready, r_wready, r_bvalid;
    logic              r_arready, r_rvalid;
    logic [c_aw-3:0]   r_awaddr;
    logic [31:0]       r_rdata;
    logic              r_ap_start, r_done, r_auto, r_gie, r_interrupt;
    logic [1:0]        r_ier, r_isr;

    logic [c_aw-1:0]   w_wr_addr, w_rd_addr;
    logic              w_wr_en, w_rd_en;
    logic              w_ctrl_wr, w_gie_wr, w_ier_wr, w_isr_wr, w_ctrl_rd;
    logic [31:0]       w_ctrl_val, w_rd_data;
    logic [1:0]        w_isr_set, w_isr_tow;
    logic              w_unused_ok;

    // Low address bits carry no meaning in a word-aligned map
    assign w_unused_ok = &{1'b0, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign w_wr_addr = {r_awaddr, 2'b00};
    assign w_rd_addr = {s_axi.araddr[c_aw-1:2], 2'b00};
    assign w_wr_en   = r_wready & s_axi.wvalid;
    assign w_rd_en   = r_arready & s_axi.arvalid;

    // Control registers live in byte lane 0 only
    assign w_ctrl_wr = w_wr_en & s_axi.wstrb[0] & (w_wr_addr == c_aw'(ADDR_CTRL));
    assign w_gie_wr  = w_wr_en & s_axi.wstrb[0] & (w_wr_addr == c_aw'(ADDR_GIE));
    assign w_ier_wr  = w_wr_en & s_axi.wstrb[0] & (w_wr_addr == c_aw'(ADDR_IER));
    assign w_isr_wr  = w_wr_en & s_axi.wstrb[0] & (w_wr_addr == c_aw'(ADDR_ISR));
    assign w_ctrl_rd = w_rd_en & (w_rd_addr == c_aw'(ADDR_CTRL));

    assign w_isr_set = {ap_ready, ap_done} & r_ier;
    assign w_isr_tow = w_isr_wr ? s_axi.wdata[1:0] : 2'b00;

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = 2'b00;
    assign ap_start      = r_ap_start;
    assign interrupt     = r_interrupt;

    // Read-data mux for the address presented on the AR channel
    always_comb begin
        w_ctrl_val             = '0;
        w_ctrl_val[CTRL_START] = r_ap_start;
        w_ctrl_val[CTRL_DONE]  = r_done;
        w_ctrl_val[CTRL_IDLE]  = ap_idle;
        w_ctrl_val[CTRL_READY] = ap_ready;
        w_ctrl_val[CTRL_AUTO]  = r_auto;
        w_rd_data              = '0;
        if (w_rd_addr == c_aw'(ADDR_CTRL)) w_rd_data = w_ctrl_val;
        if (w_rd_addr == c_aw'(ADDR_GIE))  w_rd_data = {31'd0, r_gie};
        if (w_rd_addr == c_aw'(ADDR_IER))  w_rd_data = {30'd0, r_ier};
        if (w_rd_addr == c_aw'(ADDR_ISR))  w_rd_data = {30'd0, r_isr};
        for (int i = 0; i < C_NUM_ARGS; i++) begin
            if (w_rd_addr == c_aw'(ADDR_ARG0 + 8*i))     w_rd_data = args[64*i      +: 32];
            if (w_rd_addr == c_aw'(ADDR_ARG0 + 8*i + 4)) w_rd_data = args[64*i + 32 +: 32];
        end
    end

    // Write channel FSM: address, then data, then response
    always_ff @(posedge ap_clk) begin
        if (ap_srst) begin
            r_wstate  <= W_ADDR;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_awaddr  <= '0;
        end else begin
            case (r_wstate)
                W_ADDR: if (s_axi.awvalid) begin
                    r_awaddr  <= s_axi.awaddr[c_aw-1:2];
                    r_awready <= 1'b0;
                    r_wready  <= 1'b1;
                    r_wstate  <= W_DATA;
                end
                W_DATA: if (s_axi.wvalid) begin
                    r_wready <= 1'b0;
                    r_bvalid <= 1'b1;
                    r_wstate <= W_RESP;
                end
                W_RESP: if (s_axi.bready) begin
                    r_bvalid  <= 1'b0;
                    r_awready <= 1'b1;
                    r_wstate  <= W_ADDR;
                end
                default: begin
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                    r_awready <= 1'b1;
                    r_wstate  <= W_ADDR;
                end
            endcase
        end
    end

    // Read channel FSM: capture data on AR handshake, hold until accepted
    always_ff @(posedge ap_clk) begin
        if (ap_srst) begin
            r_rstate  <= R_ADDR;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_ADDR: if (s_axi.arvalid) begin
                    r_rdata   <= w_rd_data;
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b1;
                    r_rstate  <= R_DATA;
                end
                R_DATA: if (s_axi.rready) begin
                    r_rvalid  <= 1'b0;
                    r_arready <= 1'b1;
                    r_rstate  <= R_ADDR;
                end
                default: begin
                    r_rvalid  <= 1'b0;
                    r_arready <= 1'b1;
                    r_rstate  <= R_ADDR;
                end
            endcase
        end
    end

    // Kernel control, status and interrupt registers
    always_ff @(posedge ap_clk) begin
        if (ap_srst) begin
            r_ap_start  <= 1'b0;
            r_done      <= 1'b0;
            r_auto      <= 1'b0;
            r_gie       <= 1'b0;
            r_ier       <= 2'b00;
            r_isr       <= 2'b00;
            r_interrupt <= 1'b0;
        end else begin
            // A host start request outranks the kernel's ready pulse
            if (w_ctrl_wr && s_axi.wdata[CTRL_START]) r_ap_start <= 1'b1;
            else if (ap_ready && !r_auto)             r_ap_start <= 1'b0;
            // A completion in the same cycle as a CTRL read keeps the flag set
            if (ap_done)        r_done <= 1'b1;
            else if (w_ctrl_rd) r_done <= 1'b0;
            if (w_ctrl_wr) r_auto <= s_axi.wdata[CTRL_AUTO];
            if (w_gie_wr)  r_gie  <= s_axi.wdata[0];
            if (w_ier_wr)  r_ier  <= s_axi.wdata[1:0];
            // Event sets dominate toggle-on-write
            r_isr       <= w_isr_set | (r_isr ^ w_isr_tow);
            r_interrupt <= r_gie & (|r_isr);
        end
    end

    genvar gi;
    for (gi = 0; gi < C_NUM_ARGS; gi++) begin : g_args
        localparam logic [c_aw-1:0] c_lo_addr = c_aw'(ADDR_ARG0 + 8*gi);
        localparam logic [c_aw-1:0] c_hi_addr = c_aw'(ADDR_ARG0 + 8*gi + 4);
        logic [63:0] r_arg;

        // Byte-enabled update of one 64-bit scalar argument
        always_ff @(posedge ap_clk) begin
            if (ap_srst) begin
                r_arg <= '0;
            end else if (w_wr_en && w_wr_addr == c_lo_addr) begin
                r_arg[31:0] <= strb_merge(r_arg[31:0], s_axi.wdata, s_axi.wstrb);
            end else if (w_wr_en && w_wr_addr == c_hi_addr) begin
                r_arg[63:32] <= strb_merge(r_arg[63:32], s_axi.wdata, s_axi.wstrb);
            end
        end

        assign args[64*gi +: 64] = r_arg;
    end

endmodule
`default_nettype wire
